// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_seq_pkg : ALU op encodings and op-class helpers for the sequential MDU.
// Revision    : 1.0
// ----------------------------------------------------------------------------
package mdu_seq_pkg;

  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  // Operand a is src1, operand b is src2.
  function automatic logic a_signed_op(input logic [4:0] op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic b_signed_op(input logic [4:0] op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_seq : 1 bit/cycle shift-add multiplier and restoring divider.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic            s_32,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW  = $clog2(XLEN) + 1;
  localparam int WSH = XLEN - 32;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r       = {XLEN{sgn & v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic              w32_q, w32_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_w32, w_a_neg, w_b_neg, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_fast_res;
  logic [XLEN-1:0]   w_hi, w_lo, w_quo, w_rem, w_fix;
  logic [XLEN:0]     w_sum, w_sh, w_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod, w_prod_s;
  logic [CW-1:0]     w_last;

  // Request decode: W-variants narrow both operands to their low 32 bits first.
  always_comb begin
    w_w32   = (XLEN == 64) && s_32;
    w_a_ext = w_w32 ? ext32(src1[31:0], a_signed_op(alu_op)) : src1;
    w_b_ext = w_w32 ? ext32(src2[31:0], b_signed_op(alu_op)) : src2;
    w_a_neg = a_signed_op(alu_op) & w_a_ext[XLEN-1];
    w_b_neg = b_signed_op(alu_op) & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_min   = w_w32 ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    w_div0  = is_div_op(alu_op) && (w_b_ext == '0);
    w_ovf   = ((alu_op == ALU_DIV) || (alu_op == ALU_REM)) &&
              (w_a_ext == w_min) && (w_b_ext == '1);
    w_fast  = !(is_mul_op(alu_op) || is_div_op(alu_op)) || w_div0 || w_ovf;
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = is_rem_op(alu_op) ? w_a_ext : '1;
    end else if (w_ovf) begin
      w_fast_res = is_rem_op(alu_op) ? '0 : w_a_ext;
    end
    if (w_w32) begin
      w_fast_res = ext32(w_fast_res[31:0], 1'b1);
    end
  end

  // Shared accumulator: {partial product | remainder, multiplier | quotient}.
  always_comb begin
    w_hi       = acc_q[2*XLEN-1:XLEN];
    w_lo       = acc_q[XLEN-1:0];
    w_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b_q} : '0);
    w_mul_next = {w_sum, w_lo[XLEN-1:1]};
    w_sh       = {w_hi, w_lo[XLEN-1]};
    w_diff     = w_sh - {1'b0, b_q};
    w_div_next = w_diff[XLEN] ? {w_sh[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                              : {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
    w_last     = w32_q ? CW'(31) : CW'(XLEN - 1);
  end

  always_comb begin
    w_prod   = w32_q ? (acc_q >> WSH) : acc_q;
    w_prod_s = neg_q ? -w_prod : w_prod;
    w_quo    = neg_q ? -w_lo : w_lo;
    w_rem    = rneg_q ? -w_hi : w_hi;
    case (op_q)
      ALU_MUL:                         w_fix = w_prod_s[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: w_fix = w_prod_s[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:               w_fix = w_quo;
      default:                         w_fix = w_rem;
    endcase
    if (w32_q) begin
      w_fix = ext32(w_fix[31:0], 1'b1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    w32_d       = w32_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = alu_op;
          w32_d  = w_w32;
          neg_d  = w_a_neg ^ w_b_neg;
          rneg_d = w_a_neg;
          cnt_d  = '0;
          if (is_mul_op(alu_op)) begin
            b_d   = w_a_mag;
            acc_d = {{XLEN{1'b0}}, w_b_mag};
          end else begin
            b_d   = w_b_mag;
            acc_d = {{XLEN{1'b0}}, (w_w32 ? (w_a_mag << WSH) : w_a_mag)};
          end
          if (w_fast) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = w_fast_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = is_mul_op(op_q) ? w_mul_next : w_div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == w_last) begin
          state_d = FIXUP;
          cnt_d   = '0;
        end
      end
      FIXUP: begin
        result_d    = w_fix;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      w32_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      w32_q       <= w32_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mdu_seq : vector table plus handshake/flush/reset sequences, XLEN 32 and 64.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset, flush, out_ready, s_32;
  logic [4:0]  alu_op;
  logic [63:0] src1, src2;
  logic        iv32, ir32, ov32, iv64, ir64, ov64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic        sel64;
  logic        w_ir, w_ov;
  logic [63:0] w_res;

  always #5 clock = ~clock;

  mdu_seq #(.XLEN(32)) u_dut32 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .alu_op(alu_op), .s_32(s_32), .src1(src1[31:0]), .src2(src2[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .result(res32)
  );

  mdu_seq #(.XLEN(64)) u_dut64 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(iv64), .in_ready(ir64),
    .alu_op(alu_op), .s_32(s_32), .src1(src1), .src2(src2),
    .out_valid(ov64), .out_ready(out_ready), .result(res64)
  );

  assign w_ir  = sel64 ? ir64 : ir32;
  assign w_ov  = sel64 ? ov64 : ov32;
  assign w_res = sel64 ? res64 : {32'b0, res32};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic        s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
    bit          x64;
  } vec_t;
  vec_t tv[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel64) iv64 = v;
    else       iv32 = v;
  endtask

  task automatic send(input logic [4:0] op, input logic s, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] res, input int lat,
                      input bit push);
    int n = 0;
    while (!w_ir && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (!w_ir) check("in_ready_timeout", {63'b0, w_ir}, 64'd1);
    alu_op = op; s_32 = s; src1 = a; src2 = b;
    set_valid(1'b1);
    @(posedge clock); #1;
    set_valid(1'b0);
    if (push) sb.push_back('{res, lat, cyc - 1});
  endtask

  task automatic await_out(input string nm);
    exp_t e;
    int   n = 0;
    while (!w_ov && n < 200) begin
      @(posedge clock); #1; n++;
    end
    check({nm, "_valid"}, {63'b0, w_ov}, 64'd1);
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({nm, "_res"}, w_res, e.res);
      check({nm, "_lat"}, 64'(cyc - e.t), 64'(e.lat));
    end
  endtask

  task automatic collect(input string nm);
    await_out(nm);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({nm, "_after"}, {62'b0, w_ir, w_ov}, 64'd2);
  endtask

  task automatic watch_quiet(input string nm, input int cycles);
    bit seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (w_ov) seen = 1;
    end
    check(nm, {63'b0, seen}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; s_32 = 1'b0; alu_op = '0;
    src1 = '0; src2 = '0; iv32 = 1'b0; iv64 = 1'b0; sel64 = 1'b0;

    tv.push_back('{"mul_7x6",      ALU_MUL,    0, 64'd7,          64'd6,          64'd42,         34, 0});
    tv.push_back('{"mulhu_max",    ALU_MULHU,  0, 64'hFFFFFFFF,   64'hFFFFFFFF,   64'hFFFFFFFE,   34, 0});
    tv.push_back('{"mulh_m1",      ALU_MULH,   0, 64'hFFFFFFFF,   64'hFFFFFFFF,   64'h0,          34, 0});
    tv.push_back('{"div_m7_2",     ALU_DIV,    0, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFD,   34, 0});
    tv.push_back('{"rem_m7_2",     ALU_REM,    0, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFF,   34, 0});
    tv.push_back('{"divu_by0",     ALU_DIVU,   0, 64'd100,        64'd0,          64'hFFFFFFFF,   1,  0});
    tv.push_back('{"remu_by0",     ALU_REMU,   0, 64'd100,        64'd0,          64'd100,        1,  0});
    tv.push_back('{"div_ovf",      ALU_DIV,    0, 64'h80000000,   64'hFFFFFFFF,   64'h80000000,   1,  0});
    tv.push_back('{"rem_ovf",      ALU_REM,    0, 64'h80000000,   64'hFFFFFFFF,   64'h0,          1,  0});
    tv.push_back('{"mulhsu_m2_3",  ALU_MULHSU, 0, 64'hFFFFFFFE,   64'd3,          64'hFFFFFFFF,   34, 0});
    tv.push_back('{"mul_m3_5",     ALU_MUL,    0, 64'hFFFFFFFD,   64'd5,          64'hFFFFFFF1,   34, 0});
    tv.push_back('{"divu_100_7",   ALU_DIVU,   0, 64'd100,        64'd7,          64'd14,         34, 0});
    tv.push_back('{"remu_100_7",   ALU_REMU,   0, 64'd100,        64'd7,          64'd2,          34, 0});
    tv.push_back('{"div_7_m2",     ALU_DIV,    0, 64'd7,          64'hFFFFFFFE,   64'hFFFFFFFD,   34, 0});
    tv.push_back('{"rem_7_m2",     ALU_REM,    0, 64'd7,          64'hFFFFFFFE,   64'd1,          34, 0});
    tv.push_back('{"mulh_min",     ALU_MULH,   0, 64'h80000000,   64'h80000000,   64'h40000000,   34, 0});
    tv.push_back('{"mulhu_2p32",   ALU_MULHU,  0, 64'h80000000,   64'd2,          64'd1,          34, 0});
    tv.push_back('{"bad_op",       5'h1F,      0, 64'd1,          64'd1,          64'd0,          1,  0});
    tv.push_back('{"divw_64",      ALU_DIV,    1, 64'h00000000_FFFFFFF8, 64'd2,   64'hFFFFFFFF_FFFFFFFC, 34, 1});
    tv.push_back('{"mul_64",       ALU_MUL,    0, 64'h1_0000_0000, 64'd3,         64'h3_0000_0000, 66, 1});
    tv.push_back('{"mulw_64",      ALU_MUL,    1, 64'h7FFFFFFF,   64'd2,          64'hFFFFFFFF_FFFFFFFE, 34, 1});
    tv.push_back('{"remuw_by0_64", ALU_REMU,   1, 64'h00000000_80000005, 64'h1_0000_0000, 64'hFFFFFFFF_80000005, 1, 1});

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_rdy32", {62'b0, ir32, ov32}, 64'd2);
    check("reset_res32", {32'b0, res32}, 64'd0);
    check("reset_rdy64", {62'b0, ir64, ov64}, 64'd2);
    check("reset_res64", res64, 64'd0);

    foreach (tv[i]) begin
      sel64 = tv[i].x64;
      send(tv[i].op, tv[i].s, tv[i].a, tv[i].b, tv[i].res, tv[i].lat, 1);
      collect(tv[i].nm);
    end
    sel64 = 1'b0;

    // Result held while the consumer stalls; a waiting request enters after the handshake.
    send(ALU_MUL, 0, 64'd3, 64'd4, 64'd12, 34, 1);
    await_out("hold");
    alu_op = ALU_MUL; src1 = 64'd5; src2 = 64'd5; iv32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("hold_stable", {w_res[31:0], 29'b0, w_ov, w_ir, 1'b0}, {32'd12, 29'b0, 1'b1, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("hold_handshake", {62'b0, w_ir, w_ov}, 64'd2);
    sb.push_back('{64'd25, 34, cyc});
    @(posedge clock); #1;
    iv32 = 1'b0;
    check("hold_accepted", {63'b0, w_ir}, 64'd0);
    collect("hold_next");

    // Flush ten cycles into a divide.
    send(ALU_DIV, 0, 64'd1000, 64'd3, 64'd0, 34, 0);
    repeat (9) begin
      @(posedge clock); #1;
    end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_idle", {62'b0, w_ir, w_ov}, 64'd2);
    watch_quiet("flush_no_out", 40);
    send(ALU_MUL, 0, 64'd9, 64'd9, 64'd81, 34, 1);
    collect("after_flush");

    // Reset in the middle of an operation.
    send(ALU_DIVU, 0, 64'd500, 64'd7, 64'd0, 34, 0);
    repeat (5) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset_state", {w_res[31:0], 30'b0, w_ir, w_ov}, {32'd0, 30'b0, 1'b1, 1'b0});
    watch_quiet("midreset_no_out", 40);
    send(ALU_REMU, 0, 64'd500, 64'd7, 64'd3, 34, 1);
    collect("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, abort the in-flight operation.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port alu_op, input, 5, decoded operation code (`ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU`).
REQ-008 SHALL have port s_32, input, 1, W-variant; honoured only when XLEN=64.
REQ-009 SHALL have ports src1 and src2, input, XLEN, operands.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port result, output, XLEN, operation result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIXUP, DONE; in_ready = (state==IDLE).
REQ-014 SHALL accept on in_valid && in_ready (cycle T), latching op, s_32, operands.
REQ-015 SHALL go IDLE->CALC on accept and run N iterations: N=32 if (XLEN==64 && s_32), else XLEN.
REQ-016 SHALL multiply by shift-add at 1 bit/cycle over a 2*XLEN accumulator, on magnitudes, with signs per op (MULH s*s, MULHSU s*u, MULHU u*u).
REQ-017 SHALL divide by restoring division at 1 quotient bit/cycle, on magnitudes for DIV/REM.
REQ-018 SHALL go CALC->FIXUP after N iterations; FIXUP applies sign correction (quotient negated if signs differ; remainder takes dividend sign) and selects low/high half; then ->DONE.
REQ-019 SHALL assert out_valid only in DONE; normal latency is accept at T, out_valid at T+N+2.
REQ-020 SHALL hold result and out_valid stable in DONE until out_ready; DONE->IDLE on out_valid && out_ready.
REQ-021 SHALL fast-path divide-by-zero at IDLE->DONE (out_valid at T+1): quotient all-ones, remainder = dividend.
REQ-022 SHALL fast-path signed overflow (most-negative / -1) at IDLE->DONE: quotient = dividend, remainder 0.
REQ-023 SHALL fast-path any alu_op not listed in REQ-007 at IDLE->DONE with result 0.
REQ-024 SHALL, for W-variants, use the low 32 bits of the operands and return the 32-bit result sign-extended to XLEN.
REQ-025 SHALL, when flush is high in any state, go to IDLE next cycle with out_valid low; flush has priority over accept and completion.
REQ-026 SHALL not accept a new request in the cycle the result is taken; in_ready rises the following cycle.

Reset
REQ-027 SHALL, on reset, set state IDLE, out_valid 0, result 0, iteration counter 0, accumulators 0; in_ready is 1 from the first cycle after reset.
REQ-028 SHALL, when reset arrives mid-operation, discard the operation and produce no out_valid.

Structure
REQ-029 SHALL take ALU op encodings from the shared defines header; FSM state encodings are local constants.
REQ-030 SHALL have the iteration counter width $clog2(XLEN)+1.
REQ-031 SHALL be a single module without sub-modules; an optional sub-module mdu_sign_fix for FIXUP is permitted.

Verification
REQ-032 SHALL check (XLEN=32): MUL 7*6 accepted at T -> result 42, out_valid at T+34.
REQ-033 SHALL check MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH -1*-1 -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
REQ-034 SHALL check DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each at T+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-035 SHALL check out_ready held low 5 cycles in DONE -> result stable, in_ready 0; the new request is accepted the cycle after the handshake.
REQ-036 SHALL check flush at T+10 of a DIV -> IDLE at T+11, no out_valid; a following MUL returns the correct result.
REQ-037 SHALL check (XLEN=64) DIVW s_32=1, src1=0x00000000_FFFFFFF8, src2=2 -> 0xFFFFFFFF_FFFFFFFC, out_valid at T+34.
